switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the number of switch inputs.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default DB_STABLE_CYCLES from the package (1_000_000, i.e. 10 ms at 100 MHz), the consecutive stable cycles required to accept a new level.
REQ-003 The block SHALL have port CLK100MHZ, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port SW, input, WIDTH bits, raw asynchronous switch levels.
REQ-006 The block SHALL have port SW_DB, output, WIDTH bits, debounced switch levels, which feed leading_ones.SW directly.
REQ-007 The block SHALL have port SW_CHG, output, WIDTH bits, a one-cycle pulse per bit when that bit of SW_DB changes.

Function
REQ-008 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-009 Each bit SHALL own a counter of width $clog2(STABLE_CYCLES) bits; counters are independent across bits.
REQ-010 When sync2 equals SW_DB for a bit, that bit's counter SHALL clear to 0 on the next edge.
REQ-011 When sync2 differs from SW_DB and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-012 When sync2 differs from SW_DB and the counter equals STABLE_CYCLES-1, then on the same edge SW_DB SHALL take sync2, the counter SHALL clear, and SW_CHG for that bit SHALL assert.
REQ-013 SW_CHG SHALL be registered and asserted for exactly one cycle per accepted transition, and SHALL be 0 otherwise.
REQ-014 Latency: when SW changes and is held, SW_DB SHALL change on the (STABLE_CYCLES+2)th rising edge after the change.
REQ-015 Any excursion of sync2 lasting fewer than STABLE_CYCLES cycles SHALL leave SW_DB and SW_CHG unchanged, and SHALL restart the count from 0.
REQ-016 Multiple bits changing together SHALL update in the same cycle, with the corresponding SW_CHG bits all set in that cycle.
REQ-017 The counter SHALL never exceed STABLE_CYCLES-1, so no wrap-around is possible.
REQ-018 STABLE_CYCLES < 2 SHALL be rejected at elaboration by a $error.

Reset
REQ-019 While RST is high at a clock edge, sync1, sync2, SW_DB, SW_CHG and all counters SHALL load 0.
REQ-020 Reset asserted mid-count SHALL discard the partial count; after release, the full STABLE_CYCLES+2 latency SHALL apply again.
REQ-021 A switch held high through reset SHALL appear on SW_DB on the (STABLE_CYCLES+2)th edge after RST falls, with an SW_CHG pulse.

Structure
REQ-022 Package db_pkg SHALL hold BOARD_CLK_HZ (100_000_000), DB_TIME_MS (10) and DB_STABLE_CYCLES, which is derived from these two.
REQ-023 Per-bit logic (synchronizer, counter, state bit, change pulse) SHALL live in sub-module debounce_bit, instantiated WIDTH times in a generate loop.

Verification (WIDTH=16, STABLE_CYCLES=4)
REQ-024 Reset: SW=0xFFFF, RST high for 2 cycles -> SW_DB=0x0000 and SW_CHG=0x0000 during reset; SW_DB=0xFFFF on edge 6 after release, with SW_CHG=0xFFFF for that one cycle.
REQ-025 Clean edge: SW[3] goes 0->1 and is held -> SW_DB=0x0008 on edge 6, SW_CHG=0x0008 for exactly one cycle, then 0x0000.
REQ-026 Glitch: SW[0] high for 3 cycles, then low -> SW_DB stays 0x0000 and SW_CHG is never set.
REQ-027 Bounce: SW[5] toggles every 2 cycles for 10 cycles, then is held at 1 -> a single SW_CHG[5] pulse, with SW_DB[5] rising 6 edges after the final transition.
REQ-028 Simultaneous: SW goes 0x0000->0xA5A5 -> SW_DB=0xA5A5 in one cycle with SW_CHG=0xA5A5; returning SW to 0x0000 gives SW_DB=0x0000 6 edges later, with SW_CHG=0xA5A5.
REQ-029 Reset mid-count: SW[7] rises, RST pulses at edge 4 -> SW_DB[7] stays 0, and then rises on edge 6 after RST falls.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Board-level timing constants shared by the switch debouncer.
// The stable-cycle count is derived from the board clock and the debounce window.
package db_pkg;

  localparam int BOARD_CLK_HZ = 100_000_000;
  localparam int DB_TIME_MS   = 10;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DB_STABLE_CYCLES = ms_to_cycles(BOARD_CLK_HZ, DB_TIME_MS);

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bundle: raw levels toward the debouncer, debounced levels and change pulses back.
// The master side owns the raw switches; the slave side is the debouncer.
interface switch_debounce_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_chg;

  modport master (
    output sw,
    input  sw_db,
    input  sw_chg
  );

  modport slave (
    input  sw,
    output sw_db,
    output sw_chg
  );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch lane: two-flop synchronizer, stability counter, accepted level and change pulse.
// A new level is accepted only after it differs from the held level for STABLE_CYCLES edges.
module debounce_bit #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_db,
  output logic sw_chg
);

  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          db;
  logic          chg;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      chg   <= 1'b0;
      cnt   <= '0;
    end else begin
      // synchronizer stage
      sync1 <= sw;
      sync2 <= sync1;
      chg   <= 1'b0;
      // stability stage: any sample matching the held level restarts the window
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= sync2;
        chg <= 1'b1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign sw_db  = db;
  assign sw_chg = chg;

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH independent switch inputs; SW_DB drives leading_ones.SW directly.
// Each lane is a separate debounce_bit so the bits never interact.
module switch_debounce
  import db_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_CHG
);

  if (STABLE_CYCLES < 2) begin : g_bad_cfg
    $error("switch_debounce: STABLE_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk   (CLK100MHZ),
      .rst   (RST),
      .sw    (SW[i]),
      .sw_db (SW_DB[i]),
      .sw_chg(SW_CHG[i])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce (WIDTH=16, STABLE_CYCLES=4): directed scenarios plus
// randomized switch activity compared every cycle against a queue-based reference model.
module tb_switch_debounce;

  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_debounce_if #(.WIDTH(W)) bus ();

  switch_debounce #(
    .WIDTH(W),
    .STABLE_CYCLES(S)
  ) dut (
    .CLK100MHZ(clk),
    .RST      (rst),
    .SW       (bus.sw),
    .SW_DB    (bus.sw_db),
    .SW_CHG   (bus.sw_chg)
  );

  int checks = 0;
  int errs   = 0;
  bit started = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the raw level reaches the decision point two edges late; a lane accepts
  // a new level once it has seen S consecutive samples all differing from its held level.
  bit [W-1:0] m_d1, m_d2, m_db, m_chg;
  bit         pending [W][$];

  always @(posedge clk) begin
    bit [W-1:0] ndb;
    bit [W-1:0] nchg;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_db = '0; m_chg = '0;
      for (int b = 0; b < W; b++) pending[b].delete();
    end else begin
      ndb  = m_db;
      nchg = '0;
      for (int b = 0; b < W; b++) begin
        if (m_d2[b] != m_db[b]) begin
          pending[b].push_back(m_d2[b]);
          if (pending[b].size() == S) begin
            ndb[b]  = m_d2[b];
            nchg[b] = 1'b1;
            pending[b].delete();
          end
        end else begin
          pending[b].delete();
        end
      end
      m_d2  = m_d1;
      m_d1  = bus.sw;
      m_db  = ndb;
      m_chg = nchg;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("db_vs_model", 32'(bus.sw_db), 32'(m_db));
      check("chg_vs_model", 32'(bus.sw_chg), 32'(m_chg));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the triggering change (new SW level or reset release) was applied.
  task automatic edges_after(input string tag, input logic [W-1:0] old_db,
                             input logic [W-1:0] new_db, input logic [W-1:0] mask);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e <= 5) begin
        check({tag, "_db_hold"}, 32'(bus.sw_db), 32'(old_db));
        check({tag, "_chg_idle"}, 32'(bus.sw_chg), 32'h0);
      end else if (e == 6) begin
        check({tag, "_db_new"}, 32'(bus.sw_db), 32'(new_db));
        check({tag, "_chg_pulse"}, 32'(bus.sw_chg), 32'(mask));
      end else begin
        check({tag, "_db_kept"}, 32'(bus.sw_db), 32'(new_db));
        check({tag, "_chg_drop"}, 32'(bus.sw_chg), 32'h0);
      end
    end
  endtask

  task automatic settle(input logic [W-1:0] v);
    bus.sw = v;
    repeat (8) tick();
  endtask

  initial begin
    int chg_seen;
    int hold;
    logic [W-1:0] v;

    // Reset with all switches high
    rst    = 1'b1;
    bus.sw = 16'hFFFF;
    tick();
    started = 1'b1;
    check("rst_db_c1", 32'(bus.sw_db), 32'h0);
    check("rst_chg_c1", 32'(bus.sw_chg), 32'h0);
    tick();
    check("rst_db_c2", 32'(bus.sw_db), 32'h0);
    check("rst_chg_c2", 32'(bus.sw_chg), 32'h0);
    rst = 1'b0;
    edges_after("rst_release", 16'h0000, 16'hFFFF, 16'hFFFF);
    settle(16'h0000);
    check("settle_low", 32'(bus.sw_db), 32'h0);

    // Clean single edge
    bus.sw = 16'h0008;
    edges_after("clean", 16'h0000, 16'h0008, 16'h0008);
    settle(16'h0000);

    // Short glitch never accepted
    chg_seen = 0;
    bus.sw = 16'h0001;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) bus.sw = 16'h0000;
      tick();
      if (bus.sw_chg != 16'h0 || bus.sw_db != 16'h0) chg_seen++;
    end
    check("glitch_quiet", 32'(chg_seen), 32'd0);

    // Bounce then hold high
    chg_seen = 0;
    for (int i = 0; i < 17; i++) begin
      bus.sw = (i >= 10 || ((i / 2) % 2 == 0)) ? 16'h0020 : 16'h0000;
      tick();
      if (bus.sw_chg[5]) chg_seen++;
      if (i >= 11) begin
        check("bounce_db", 32'(bus.sw_db), (i >= 13) ? 32'h20 : 32'h0);
        check("bounce_chg", 32'(bus.sw_chg), (i == 13) ? 32'h20 : 32'h0);
      end
    end
    check("bounce_pulses", 32'(chg_seen), 32'd1);
    settle(16'h0000);

    // Simultaneous multi-bit change both directions
    bus.sw = 16'hA5A5;
    edges_after("simul_up", 16'h0000, 16'hA5A5, 16'hA5A5);
    bus.sw = 16'h0000;
    edges_after("simul_dn", 16'hA5A5, 16'h0000, 16'hA5A5);

    // Reset mid-count discards progress
    bus.sw = 16'h0080;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_db", 32'(bus.sw_db), 32'h0);
    rst = 1'b0;
    edges_after("midrst", 16'h0000, 16'h0080, 16'h0080);
    settle(16'h0000);

    // Randomized activity against the model
    hold = 0;
    v = '0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        v = v ^ 16'($urandom() & $urandom());
        hold = $urandom_range(1, 8);
      end
      hold--;
      bus.sw = v;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
